m_lsu: RTL and testbench
========================

# m_lsu

Memory-stage load/store initiator for the five-stage MIPS pipeline. It accepts one load or store per instruction from the M stage, drives a word-addressed data memory over a req/ack handshake with per-byte enables, and returns an aligned, sign- or zero-extended load result. It stalls the pipeline for the whole transaction and flags misaligned accesses without touching memory.

## Interface
- `ACK_TIMEOUT`, default 0: reserved; 0 means no timeout. The block waits indefinitely for `mem_ack`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: M stage holds a memory instruction. It stays asserted until `stall` is seen low.
- `issue_we` in 1: 1 = store, 0 = load.
- `issue_size` in 2: 00 word, 01 byte, 10 half; 11 is treated as word.
- `issue_unsigned` in 1: zero-extend the load result (lbu/lhu).
- `issue_addr` in 32: byte address.
- `issue_wdata` in 32: store data, right-justified.
- `stall` out 1: freeze F/D/E/M.
- `done` out 1: one-cycle pulse; the transaction is finished.
- `rdata` out 32: load result, valid while `done` is high.
- `exc_adel` out 1: misaligned load, valid while `done` is high.
- `exc_ades` out 1: misaligned store, valid while `done` is high.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `mem_addr` out 32: `{issue_addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables; bit i covers bits [8i+7:8i].
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory accepted or completed the request.
- `mem_rdata` in 32: read word, valid in the `mem_ack` cycle.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - On `issue_valid`, capture `we`, `size`, `unsigned`, `addr[1:0]`, the memory fields, and the misalign check.
  - Aligned access → REQ. Misaligned access (word with `addr[1:0]`≠0, or half with `addr[0]`≠0) → DONE with no memory request.
- **REQ**
  - `mem_req`=1. All `mem_*` outputs come from the captured registers and stay stable until ack.
  - On `mem_ack`, capture `mem_rdata` and go to DONE.
- **DONE**
  - `done`=1, `stall`=0, then return to IDLE.
  - `issue_valid` is ignored in DONE, because the pipeline is still presenting the same instruction.
- **Store lanes**
  - Byte: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=4'b0001<<addr[1:0].
  - Half: `mem_wdata`={2{wdata[15:0]}}, `mem_be`=4'b0011<<{addr[1],1'b0}.
  - Word: `mem_be`=4'b1111.
- **Loads**
  - `mem_be`=4'b1111, `mem_wdata`=0.
  - `rdata` selects the byte or half indicated by the captured `addr[1:0]`.
  - The selected data is sign-extended unless `unsigned` is set. For word loads the `unsigned` flag is ignored.
- **Misaligned access**
  - `rdata`=0 in DONE.
  - `exc_adel` = !we, `exc_ades` = we.
- **Stall**
  - `stall` = (IDLE & `issue_valid`) | REQ. This is combinational from state and `issue_valid`.
- **Reset**
  - All registers clear and the state goes to IDLE.
  - A transaction in REQ is abandoned; `mem_req` is 0 the cycle after reset.

## Timing
- Reset values: `stall`=0 (with `issue_valid`=0), `done`=0, `rdata`=0, `exc_*`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
- **Aligned access:** issue in cycle T; `mem_req` from T+1; ack in cycle A ≥ T+1; `done` in A+1.
  - Minimum latency is 3 cycles issue-to-done; the pipeline advances at the end of the `done` cycle.
- **Misaligned access:** `done` in T+1, and `mem_req` is never asserted.
- `mem_ack` while not in REQ is ignored.
- `mem_ack` arriving in the same cycle that `mem_req` first rises is accepted.
- `done` always lasts exactly one cycle.
- Back-to-back instructions: the next issue can be accepted in the cycle after DONE.
- `issue_*` changes while in REQ have no effect.

## Structure
- Package `lsu_pkg` holds:
  - size constants `LSU_WORD`=2'b00, `LSU_BYTE`=2'b01, `LSU_HALF`=2'b10;
  - the state enum {IDLE, REQ, DONE};
  - a misalign-check function.
- Sub-module `m_lsu_lane` is combinational and contains:
  - store lane replication plus byte-enable generation;
  - load extract plus extension.
- The FSM and capture registers stay in `m_lsu`.

## Test plan
- Word store, ack after 2 cycles: sw `addr`=0x0000_0010, `wdata`=0x1234_5678.
  - `mem_addr`=0x10, `mem_be`=1111, `mem_wdata`=0x1234_5678 held for 2 req cycles.
  - `done` arrives 4 cycles after issue; `stall` is high for 3 cycles.
- Byte store: sb `addr`=0x0000_0023, `wdata`=0xFFFF_FFAB.
  - `mem_addr`=0x20, `mem_be`=1000, `mem_wdata`=0xABAB_ABAB.
- Signed half load: lh `addr`=0x0000_0006, `mem_rdata`=0x8001_7FFF, immediate ack.
  - `rdata`=0xFFFF_8001 during `done`.
  - The same access with `issue_unsigned` set gives 0x0000_8001.
- Signed byte load: lb `addr`=0x0000_0001, `mem_rdata`=0x0000_8000.
  - `rdata`=0xFFFF_FF80.
- Misaligned accesses:
  - lw at 0x0000_0002: no `mem_req`, `done`+`exc_adel` at T+1, `rdata`=0.
  - sh at 0x0000_0003: `exc_ades` instead.
- Reset mid-transaction: assert `reset` while in REQ with ack withheld.
  - `mem_req`=0 next cycle, no `done`, state IDLE.
  - A subsequent lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: access sizes, FSM states
// and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] LSU_WORD = 2'b00;
    localparam logic [1:0] LSU_BYTE = 2'b01;
    localparam logic [1:0] LSU_HALF = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Size 2'b11 falls into the word rule.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            LSU_BYTE: return 1'b0;
            LSU_HALF: return addr_lo[0];
            default:  return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/m_lsu_lane.sv
// Combinational lane logic: store data replication and byte enables on the
// issue side, byte/half extraction and extension on the load-return side.
module m_lsu_lane
    import lsu_pkg::*;
(
    input  logic        st_we,
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_mem_wdata,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        st_be        = 4'b1111;
        st_mem_wdata = '0;
        if (st_we) begin
            case (st_size)
                LSU_BYTE: begin
                    st_be        = 4'b0001 << st_addr_lo;
                    st_mem_wdata = {4{st_wdata[7:0]}};
                end
                LSU_HALF: begin
                    st_be        = 4'b0011 << {st_addr_lo[1], 1'b0};
                    st_mem_wdata = {2{st_wdata[15:0]}};
                end
                default: st_mem_wdata = st_wdata;
            endcase
        end
    end

    always_comb begin
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            LSU_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            LSU_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:  ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store initiator: captures one memory instruction, runs a
// req/ack transaction on the data memory and stalls the pipeline until done.
module m_lsu
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [1:0]  issue_size,
    input  logic        issue_unsigned,
    input  logic [31:0] issue_addr,
    input  logic [31:0] issue_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Timeout is reserved; only the wait-forever behaviour exists.
    if (ACK_TIMEOUT != 0) begin : g_timeout_unsupported
        $error("m_lsu: ACK_TIMEOUT is reserved and must be 0");
    end

    lsu_state_e  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  addr_lo_q;
    logic        mis_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [3:0]  st_be;
    logic [31:0] st_mem_wdata;
    logic [31:0] ld_data;

    m_lsu_lane u_lane (
        .st_we        (issue_we),
        .st_size      (issue_size),
        .st_addr_lo   (issue_addr[1:0]),
        .st_wdata     (issue_wdata),
        .st_be        (st_be),
        .st_mem_wdata (st_mem_wdata),
        .ld_size      (size_q),
        .ld_unsigned  (unsigned_q),
        .ld_addr_lo   (addr_lo_q),
        .ld_word      (mem_rdata),
        .ld_data      (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= LSU_WORD;
            unsigned_q <= 1'b0;
            addr_lo_q  <= 2'b00;
            mis_q      <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: if (issue_valid) begin
                    we_q       <= issue_we;
                    size_q     <= issue_size;
                    unsigned_q <= issue_unsigned;
                    addr_lo_q  <= issue_addr[1:0];
                    mis_q      <= lsu_misaligned(issue_size, issue_addr[1:0]);
                    addr_q     <= {issue_addr[31:2], 2'b00};
                    be_q       <= st_be;
                    wdata_q    <= st_mem_wdata;
                    rdata_q    <= '0;
                    state      <= lsu_misaligned(issue_size, issue_addr[1:0]) ? DONE : REQ;
                end
                REQ: if (mem_ack) begin
                    rdata_q <= ld_data;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall     = ((state == IDLE) && issue_valid) || (state == REQ);
    assign done      = (state == DONE);
    assign rdata     = done ? rdata_q : '0;
    assign exc_adel  = done && mis_q && !we_q;
    assign exc_ades  = done && mis_q && we_q;
    assign mem_req   = (state == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_m_lsu.sv
// Self-checking bench for m_lsu: directed cases plus randomized transactions
// compared against an arithmetic model of the load/store rules.
module tb_m_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_we;
    logic [1:0]  issue_size;
    logic        issue_unsigned;
    logic [31:0] issue_addr;
    logic [31:0] issue_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    m_lsu dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_we       (issue_we),
        .issue_size     (issue_size),
        .issue_unsigned (issue_unsigned),
        .issue_addr     (issue_addr),
        .issue_wdata    (issue_wdata),
        .stall          (stall),
        .done           (done),
        .rdata          (rdata),
        .exc_adel       (exc_adel),
        .exc_ades       (exc_ades),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: an access of nb bytes is aligned when addr is a multiple of nb;
    // stores replicate the low nb bytes across the word, loads shift and extend.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rword, output logic mis,
                                  output logic [3:0] be, output logic [31:0] mw,
                                  output logic [31:0] rd);
        int nb;
        int lo;
        longint mask, piece, acc, val;
        nb   = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
        lo   = int'(addr % 32'd4);
        mis  = (lo % nb) != 0;
        mask = (64'sd1 <<< (8 * nb)) - 1;
        rd   = '0;
        if (we) begin
            be    = 4'(((1 << nb) - 1) << lo);
            piece = longint'(wdata) & mask;
            acc   = 0;
            for (int i = 0; i < 4 / nb; i++) acc |= piece << (8 * nb * i);
            mw = 32'(acc);
        end else begin
            be  = 4'hF;
            mw  = '0;
            val = (longint'(rword) >> (8 * lo)) & mask;
            if (!uns && nb < 4 && ((val >> (8 * nb - 1)) & 1) == 1) val |= ~mask;
            rd = mis ? 32'd0 : 32'(val);
        end
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            mem_ack     = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            #1;
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_req", 32'(mem_req), 32'd0);
        end
    endtask

    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input int ack_delay);
        logic mis;
        logic [3:0] be;
        logic [31:0] mw, rd;
        model(we, size, uns, addr, wdata, rword, mis, be, mw, rd);
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_we       = we;
        issue_size     = size;
        issue_unsigned = uns;
        issue_addr     = addr;
        issue_wdata    = wdata;
        mem_ack        = 1'($urandom_range(0, 1));
        mem_rdata      = $urandom;
        #1;
        check("issue_stall", 32'(stall), 32'd1);
        check("issue_done", 32'(done), 32'd0);
        check("issue_req", 32'(mem_req), 32'd0);
        if (!mis) begin
            for (int k = 0; k <= ack_delay; k++) begin
                @(negedge clk);
                issue_we       = 1'($urandom_range(0, 1));
                issue_size     = 2'($urandom_range(0, 3));
                issue_unsigned = 1'($urandom_range(0, 1));
                issue_addr     = $urandom;
                issue_wdata    = $urandom;
                mem_ack        = (k == ack_delay);
                mem_rdata      = (k == ack_delay) ? rword : $urandom;
                #1;
                check("req_req", 32'(mem_req), 32'd1);
                check("req_we", 32'(mem_we), 32'(we));
                check("req_addr", mem_addr, {addr[31:2], 2'b00});
                check("req_be", 32'(mem_be), 32'(be));
                check("req_wdata", mem_wdata, mw);
                check("req_stall", 32'(stall), 32'd1);
                check("req_done", 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check("done_done", 32'(done), 32'd1);
        check("done_stall", 32'(stall), 32'd0);
        check("done_req", 32'(mem_req), 32'd0);
        check("done_adel", 32'(exc_adel), 32'(mis && !we));
        check("done_ades", 32'(exc_ades), 32'(mis && we));
        if (!we || mis) check("done_rdata", rdata, rd);
    endtask

    initial begin
        reset          = 1'b1;
        issue_valid    = 1'b0;
        issue_we       = 1'b0;
        issue_size     = 2'b00;
        issue_unsigned = 1'b0;
        issue_addr     = '0;
        issue_wdata    = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_adel", 32'(exc_adel), 32'd0);
        check("rst_ades", 32'(exc_ades), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // Directed cases from the block's reference scenarios.
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0, 1);
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'hFFFF_FFAB, 32'h0, 0);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 0);
        run_txn(1'b0, 2'b10, 1'b1, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 0);
        run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_8000, 2);
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0003, 32'hCAFE_F00D, 32'h0, 0);
        run_txn(1'b0, 2'b11, 1'b1, 32'h0000_0104, 32'h0, 32'h8765_4321, 1);
        idle_cycles(1);

        // Reset while waiting for ack abandons the transaction.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_we    = 1'b0;
        issue_size  = 2'b00;
        issue_addr  = 32'h0000_0040;
        mem_ack     = 1'b0;
        @(negedge clk);
        #1;
        check("rstreq_req", 32'(mem_req), 32'd1);
        reset       = 1'b1;
        issue_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rstreq_req_after", 32'(mem_req), 32'd0);
        check("rstreq_done", 32'(done), 32'd0);
        check("rstreq_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        idle_cycles(1);
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, 1);

        // Randomized traffic, roughly half forced aligned, with idle gaps.
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
        idle_cycles(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
